bus_arbiter: RTL and testbench

Request arbiter in front of the MESI bus controller. Samples the per-CPU L1 request lines (dREN, dWEN, ccwrite) and picks one requester at a time, round-robin. Presents that requester and its transaction type to the bus controller through a valid/ready handshake. Holds the grant until the bus controller signals transaction completion; the controller then needs no priority encoding of its own.

---
 rtl/bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_bus_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter between the per-CPU L1 request lines and the MESI bus controller.
// Optional build macro BUS_ARB_EVICT_PRIORITY_EN: pending evictions win over all other request types.
module bus_arbiter #(
    parameter int CPUS          = 4,
    parameter int CPU_ID_LENGTH = $clog2(CPUS)
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS-1:0]          ccwrite,
    input  logic                     req_ready,
    input  logic                     txn_done,
    output logic                     req_valid,
    output logic [CPU_ID_LENGTH-1:0] req_cpu,
    output logic [1:0]               req_type,
    output logic [CPUS-1:0]          grant,
    output logic                     busy,
    output logic [1:0]               dbg_state_o,
    output logic [CPU_ID_LENGTH-1:0] dbg_rr_ptr_o
);

    // Handshake: the controller takes a transaction on a rising edge where req_valid and
    // req_ready are both high; req_cpu/req_type stay stable from offer until txn_done.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_OFFER = 2'd1, S_BUSY = 2'd2, S_RELEASE = 2'd3} state_t;

    localparam logic [1:0] T_INV = 2'd0, T_READ = 2'd1, T_READX = 2'd2, T_EVICT = 2'd3;
`ifdef BUS_ARB_EVICT_PRIORITY_EN
    localparam bit EVICT_PRIO = 1'b1;
`else
    localparam bit EVICT_PRIO = 1'b0;
`endif

    state_t                   state_q, state_d;
    logic [CPU_ID_LENGTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [CPU_ID_LENGTH-1:0] req_cpu_q, req_cpu_d;
    logic [1:0]               req_type_q, req_type_d;
    logic                     req_valid_q, req_valid_d;

    logic [CPUS-1:0]          pending, mask, cand;
    logic                     win_found;
    logic [CPU_ID_LENGTH-1:0] win_idx;
    logic [1:0]               win_type;

    assign pending = dREN | dWEN | ccwrite;

    // The CPU just served is masked in RELEASE: its lines may lag txn_done by a cycle.
    always_comb begin
        int idx;
        logic [CPU_ID_LENGTH-1:0] idx_b;
        mask = '0;
        for (int i = 0; i < CPUS; i++) begin
            mask[i] = (state_q == S_RELEASE) && (req_cpu_q == CPU_ID_LENGTH'(i));
        end
        cand = pending & ~mask;
        if (EVICT_PRIO && (|(dWEN & ~mask))) begin
            cand = dWEN & ~mask;
        end
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        idx_b     = '0;
        for (int i = 0; i < CPUS; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= CPUS) idx = idx - CPUS;
            idx_b = idx[CPU_ID_LENGTH-1:0];
            if (!win_found && cand[idx_b]) begin
                win_found = 1'b1;
                win_idx   = idx_b;
            end
        end
        if (dWEN[win_idx])                         win_type = T_EVICT;
        else if (dREN[win_idx] && ccwrite[win_idx]) win_type = T_READX;
        else if (dREN[win_idx])                    win_type = T_READ;
        else                                       win_type = T_INV;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        req_cpu_d   = req_cpu_q;
        req_type_d  = req_type_q;
        req_valid_d = req_valid_q;
        case (state_q)
            S_IDLE, S_RELEASE: begin
                state_d = S_IDLE;
                if (win_found) begin
                    state_d     = S_OFFER;
                    req_cpu_d   = win_idx;
                    req_type_d  = win_type;
                    req_valid_d = 1'b1;
                end
            end
            S_OFFER: begin
                if (req_ready) begin
                    state_d     = S_BUSY;
                    req_valid_d = 1'b0;
                    rr_ptr_d    = (req_cpu_q == CPU_ID_LENGTH'(CPUS - 1)) ? '0
                                                                          : req_cpu_q + CPU_ID_LENGTH'(1);
                end else if (!pending[req_cpu_q]) begin
                    state_d     = S_IDLE;
                    req_valid_d = 1'b0;
                end
            end
            S_BUSY: begin
                if (txn_done) state_d = S_RELEASE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            req_cpu_q   <= '0;
            req_type_q  <= T_INV;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            req_cpu_q   <= req_cpu_d;
            req_type_q  <= req_type_d;
            req_valid_q <= req_valid_d;
        end
    end

    always_comb begin
        grant = '0;
        if (state_q == S_OFFER || state_q == S_BUSY) begin
            for (int i = 0; i < CPUS; i++) begin
                grant[i] = (req_cpu_q == CPU_ID_LENGTH'(i));
            end
        end
    end

    assign req_valid    = req_valid_q;
    assign req_cpu      = req_cpu_q;
    assign req_type     = req_type_q;
    assign busy         = (state_q == S_BUSY);
    assign dbg_state_o  = state_q;
    assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a 4-CPU instance for the main scenarios and a 3-CPU instance for wrap/reset.
module tb_bus_arbiter;

`ifdef BUS_ARB_EVICT_PRIORITY_EN
    localparam bit EVICT_PRIO = 1'b1;
`else
    localparam bit EVICT_PRIO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       nrst;
    logic [3:0] dren, dwen, ccw;
    logic       ready, done;
    logic       valid, busy;
    logic [1:0] cpu, typ, st, rr;
    logic [3:0] grant;

    logic [2:0] dren3, dwen3, ccw3;
    logic       ready3, done3;
    logic       valid3, busy3;
    logic [1:0] cpu3, typ3, st3, rr3;
    logic [2:0] grant3;

    int         n_pass = 0;
    int         n_total = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_e;

    always #5 clk = ~clk;

    bus_arbiter #(.CPUS(4)) dut (
        .CLK(clk), .nRST(nrst), .dREN(dren), .dWEN(dwen), .ccwrite(ccw),
        .req_ready(ready), .txn_done(done), .req_valid(valid), .req_cpu(cpu),
        .req_type(typ), .grant(grant), .busy(busy), .dbg_state_o(st), .dbg_rr_ptr_o(rr)
    );

    bus_arbiter #(.CPUS(3)) dut3 (
        .CLK(clk), .nRST(nrst), .dREN(dren3), .dWEN(dwen3), .ccwrite(ccw3),
        .req_ready(ready3), .txn_done(done3), .req_valid(valid3), .req_cpu(cpu3),
        .req_type(typ3), .grant(grant3), .busy(busy3), .dbg_state_o(st3), .dbg_rr_ptr_o(rr3)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic clear_inputs;
        dren = '0; dwen = '0; ccw = '0; ready = 1'b0; done = 1'b0;
        dren3 = '0; dwen3 = '0; ccw3 = '0; ready3 = 1'b0; done3 = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        nrst = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
        tick();
    endtask

    task automatic wait_offer(input int max, output int cycles);
        cycles = 0;
        while (!valid && cycles < max) begin
            tick();
            cycles++;
        end
        if (!valid) begin
            n_total++;
            $display("FAIL offer_timeout: req_valid still 0 after %0d cycles", cycles);
        end
    endtask

    task automatic test_reset;
        clear_inputs();
        nrst = 1'b0;
        tick();
        n_total++; if ({valid, busy} !== 2'b00) $display("FAIL reset_valid_busy: got %b, expected 00", {valid, busy}); else n_pass++;
        n_total++; if ({cpu, typ} !== 4'h0) $display("FAIL reset_cpu_type: got %h, expected 0", {cpu, typ}); else n_pass++;
        n_total++; if (grant !== 4'h0) $display("FAIL reset_grant: got %b, expected 0000", grant); else n_pass++;
        n_total++; if ({st, rr} !== 4'h0) $display("FAIL reset_state_rr: got state=%0d rr=%0d, expected 0 0", st, rr); else n_pass++;
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_single;
        done = 1'b1;
        tick();
        done = 1'b0;
        n_total++; if (st !== 2'd0) $display("FAIL stray_done: state=%0d, expected 0", st); else n_pass++;
        dren = 4'b0100;
        exp_q.push_back({2'd2, 2'd1});
        tick();
        n_total++; if (valid !== 1'b1) $display("FAIL single_latency: req_valid=%b, expected 1", valid); else n_pass++;
        exp_e = exp_q.pop_front();
        n_total++; if ({cpu, typ} !== exp_e) $display("FAIL single_offer: cpu=%0d type=%0d, expected cpu=%0d type=%0d", cpu, typ, exp_e[3:2], exp_e[1:0]); else n_pass++;
        n_total++; if (grant !== 4'b0100) $display("FAIL single_grant: got %b, expected 0100", grant); else n_pass++;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        n_total++; if ({busy, valid, rr} !== {1'b1, 1'b0, 2'd3}) $display("FAIL single_accept: busy=%b valid=%b rr=%0d, expected 1 0 3", busy, valid, rr); else n_pass++;
        tick();
        n_total++; if ({busy, grant} !== {1'b1, 4'b0100}) $display("FAIL single_hold: busy=%b grant=%b, expected 1 0100", busy, grant); else n_pass++;
        done = 1'b1;
        tick();
        done = 1'b0;
        n_total++; if ({st, grant} !== {2'd3, 4'b0000}) $display("FAIL single_release: state=%0d grant=%b, expected 3 0000", st, grant); else n_pass++;
        tick();
        dren = '0;
        n_total++; if ({st, valid} !== {2'd0, 1'b0}) $display("FAIL single_masked_idle: state=%0d valid=%b, expected 0 0", st, valid); else n_pass++;
        tick();
        n_total++; if ({st, rr} !== {2'd0, 2'd3}) $display("FAIL single_rr_end: state=%0d rr=%0d, expected 0 3", st, rr); else n_pass++;
    endtask

    task automatic test_round_robin;
        int c, gap, prev;
        do_reset();
        dren  = 4'b1111;
        ready = 1'b1;
        prev  = -1;
        for (int k = 0; k < 5; k++) exp_q.push_back({2'(k % 4), 2'd1});
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                done = 1'b1;
                tick();
                done = 1'b0;
                wait_offer(10, c);
                gap = c + 1;
                n_total++; if (gap !== 2) $display("FAIL rr_gap: done-to-valid %0d cycles, expected 2", gap); else n_pass++;
            end else begin
                wait_offer(5, c);
            end
            exp_e = exp_q.pop_front();
            n_total++; if ({cpu, typ} !== exp_e) $display("FAIL rr_order: cpu=%0d type=%0d, expected cpu=%0d type=%0d", cpu, typ, exp_e[3:2], exp_e[1:0]); else n_pass++;
            n_total++; if (int'(cpu) == prev) $display("FAIL rr_repeat: cpu=%0d granted twice, expected a different cpu", cpu); else n_pass++;
            prev = int'(cpu);
            tick();
            n_total++; if (busy !== 1'b1) $display("FAIL rr_busy: busy=%b, expected 1", busy); else n_pass++;
            tick();
            tick();
        end
        dren = '0;
        done = 1'b1;
        tick();
        done  = 1'b0;
        ready = 1'b0;
        tick();
        n_total++; if ({st, rr} !== {2'd0, 2'd1}) $display("FAIL rr_final: state=%0d rr=%0d, expected 0 1", st, rr); else n_pass++;
    endtask

    task automatic test_evict_priority;
        int c;
        do_reset();
        dren  = 4'b0010;
        ready = 1'b1;
        exp_q.push_back({2'd1, 2'd1});
        wait_offer(5, c);
        exp_e = exp_q.pop_front();
        n_total++; if ({cpu, typ} !== exp_e) $display("FAIL evict_setup: cpu=%0d type=%0d, expected cpu=%0d type=%0d", cpu, typ, exp_e[3:2], exp_e[1:0]); else n_pass++;
        tick();
        dren = '0;
        done = 1'b1;
        tick();
        done  = 1'b0;
        ready = 1'b0;
        tick();
        n_total++; if ({st, rr} !== {2'd0, 2'd2}) $display("FAIL evict_rr2: state=%0d rr=%0d, expected 0 2", st, rr); else n_pass++;
        dren = 4'b0001;
        dwen = 4'b0010;
        exp_q.push_back(EVICT_PRIO ? {2'd1, 2'd3} : {2'd0, 2'd1});
        tick();
        exp_e = exp_q.pop_front();
        n_total++; if ({valid, cpu, typ} !== {1'b1, exp_e}) $display("FAIL evict_pick: valid=%b cpu=%0d type=%0d, expected 1 cpu=%0d type=%0d", valid, cpu, typ, exp_e[3:2], exp_e[1:0]); else n_pass++;
        dren = '0;
        dwen = '0;
        tick();
        n_total++; if ({st, valid, rr} !== {2'd0, 1'b0, 2'd2}) $display("FAIL evict_withdraw: state=%0d valid=%b rr=%0d, expected 0 0 2", st, valid, rr); else n_pass++;
    endtask

    task automatic test_withdraw;
        dren = 4'b1000;
        ccw  = 4'b1000;
        exp_q.push_back({2'd3, 2'd2});
        tick();
        exp_e = exp_q.pop_front();
        n_total++; if ({valid, cpu, typ} !== {1'b1, exp_e}) $display("FAIL wd_offer: valid=%b cpu=%0d type=%0d, expected 1 cpu=%0d type=%0d", valid, cpu, typ, exp_e[3:2], exp_e[1:0]); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) ccw = '0;
            tick();
            n_total++; if ({valid, cpu, typ} !== {1'b1, 2'd3, 2'd2}) $display("FAIL wd_hold: valid=%b cpu=%0d type=%0d, expected 1 3 2", valid, cpu, typ); else n_pass++;
        end
        dren = '0;
        tick();
        n_total++; if ({st, valid, rr} !== {2'd0, 1'b0, 2'd2}) $display("FAIL wd_drop: state=%0d valid=%b rr=%0d, expected 0 0 2", st, valid, rr); else n_pass++;
        dren = 4'b1000;
        exp_q.push_back({2'd3, 2'd1});
        tick();
        exp_e = exp_q.pop_front();
        n_total++; if ({valid, cpu, typ} !== {1'b1, exp_e}) $display("FAIL wd_reoffer: valid=%b cpu=%0d type=%0d, expected 1 cpu=%0d type=%0d", valid, cpu, typ, exp_e[3:2], exp_e[1:0]); else n_pass++;
        dren  = '0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        n_total++; if ({busy, rr} !== {1'b1, 2'd0}) $display("FAIL accept_wins: busy=%b rr=%0d, expected 1 0", busy, rr); else n_pass++;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
    endtask

    task automatic test_release_mask;
        int c;
        do_reset();
        dren  = 4'b0010;
        ready = 1'b1;
        exp_q.push_back({2'd1, 2'd1});
        wait_offer(5, c);
        exp_e = exp_q.pop_front();
        n_total++; if ({cpu, typ} !== exp_e) $display("FAIL rel_first: cpu=%0d type=%0d, expected cpu=%0d type=%0d", cpu, typ, exp_e[3:2], exp_e[1:0]); else n_pass++;
        tick();
        ready = 1'b0;
        dren  = 4'b0110;
        tick();
        tick();
        n_total++; if ({busy, cpu, valid} !== {1'b1, 2'd1, 1'b0}) $display("FAIL rel_busy_hold: busy=%b cpu=%0d valid=%b, expected 1 1 0", busy, cpu, valid); else n_pass++;
        done = 1'b1;
        tick();
        done = 1'b0;
        n_total++; if (st !== 2'd3) $display("FAIL rel_state: state=%0d, expected 3", st); else n_pass++;
        exp_q.push_back({2'd2, 2'd1});
        tick();
        dren = 4'b0100;
        exp_e = exp_q.pop_front();
        n_total++; if ({valid, cpu, typ} !== {1'b1, exp_e}) $display("FAIL rel_next: valid=%b cpu=%0d type=%0d, expected 1 cpu=%0d type=%0d", valid, cpu, typ, exp_e[3:2], exp_e[1:0]); else n_pass++;
        dren = '0;
        tick();
    endtask

    task automatic test_cpus3;
        do_reset();
        dren3  = 3'b100;
        ready3 = 1'b1;
        exp_q.push_back({2'd2, 2'd1});
        tick();
        exp_e = exp_q.pop_front();
        n_total++; if ({valid3, cpu3, typ3} !== {1'b1, exp_e}) $display("FAIL c3_offer: valid=%b cpu=%0d type=%0d, expected 1 cpu=%0d type=%0d", valid3, cpu3, typ3, exp_e[3:2], exp_e[1:0]); else n_pass++;
        tick();
        n_total++; if ({busy3, rr3, grant3} !== {1'b1, 2'd0, 3'b100}) $display("FAIL c3_wrap: busy=%b rr=%0d grant=%b, expected 1 0 100", busy3, rr3, grant3); else n_pass++;
        nrst = 1'b0;
        #1;
        n_total++; if ({valid3, busy3, cpu3, typ3, grant3, st3} !== 11'd0) $display("FAIL c3_async_reset: valid=%b busy=%b cpu=%0d type=%0d grant=%b state=%0d, expected all 0", valid3, busy3, cpu3, typ3, grant3, st3); else n_pass++;
        clear_inputs();
        tick();
        nrst = 1'b1;
        tick();
        n_total++; if ({st3, valid3} !== 3'd0) $display("FAIL c3_post_reset: state=%0d valid=%b, expected 0 0", st3, valid3); else n_pass++;
    endtask

    initial begin
        nrst = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_evict_priority();
        test_withdraw();
        test_release_mask();
        test_cpus3();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks done", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
